// File: rtl/instr_rom_responder.sv
// ---------------------------------------------------------------------------
// instr_rom_responder
//
// Responder side of the instruction-fetch interface. Accepts one fetch at a
// time, reads the 32-bit instruction word from a synchronous ROM (1-cycle
// read latency), optionally stretches the response by WAIT_CYCLES cycles and
// flags misaligned or out-of-range addresses with an error response.
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   resetn      synchronous active-low reset
//   req_valid   fetch request valid
//   req_ready   responder can accept a request (IDLE only)
//   req_addr    fetch byte address, sampled only at accept
//   resp_valid  response valid
//   resp_ready  requester accepts the response
//   resp_data   instruction word (0 on an error response)
//   resp_err    misaligned or out-of-range request
//   rom_addr    registered word address to the ROM
//   rom_data    ROM read data, valid the cycle after rom_addr is sampled
// ---------------------------------------------------------------------------
module instr_rom_responder #(
  parameter int ADDR_W      = 32,
  parameter int ROM_AW      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_WAIT,
    S_RESP
  } state_t;

  // Counter preload: WAIT lasts WAIT_CYCLES cycles, counting down to zero.
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                addr_bad;

  // Illegal when not word aligned or when any bit above the ROM window is set.
  assign addr_bad = (req_addr[1:0] != 2'b00) ||
                    ((req_addr >> (ROM_AW + 2)) != '0);

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (addr_bad) begin
            // Error skips the ROM entirely; rom_addr keeps its old value.
            resp_data_d = 32'd0;
            resp_err_d  = 1'b1;
            state_d     = S_RESP;
          end else begin
            rom_addr_d = req_addr[ROM_AW+1:2];
            state_d    = S_READ;
          end
        end
      end
      // ROM samples rom_addr at the end of this cycle.
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        resp_data_d = rom_data;
        resp_err_d  = 1'b0;
        if (WAIT_CYCLES == 0) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Ready only in IDLE, which forces a one-cycle bubble after each response.
  assign req_ready  = resetn && (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign rom_addr   = rom_addr_q;

endmodule

// File: tb/tb_instr_rom_responder.sv
// ---------------------------------------------------------------------------
// tb_instr_rom_responder
//
// Self-checking bench: a WAIT_CYCLES=1 instance driven with directed and
// random fetches, plus a WAIT_CYCLES=0 instance for the zero-wait build.
// Expected data, error flag and latency come from a plain address-rule
// reference model over a behavioural ROM array.
// ---------------------------------------------------------------------------
module tb_instr_rom_responder;

  localparam int W1 = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  // WAIT_CYCLES=1 instance
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;

  // WAIT_CYCLES=0 instance
  logic        req_valid0 = 1'b0, req_ready0;
  logic [31:0] req_addr0 = 32'd0;
  logic        resp_valid0, resp_ready0 = 1'b0;
  logic [31:0] resp_data0;
  logic        resp_err0;
  logic [9:0]  rom_addr0;
  logic [31:0] rom_data0;

  logic [31:0] rom_mem [0:1023];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous ROMs, one read port per instance.
  always @(posedge clk) rom_data  <= rom_mem[rom_addr];
  always @(posedge clk) rom_data0 <= rom_mem[rom_addr0];

  instr_rom_responder #(.ADDR_W(32), .ROM_AW(10), .WAIT_CYCLES(W1)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  instr_rom_responder #(.ADDR_W(32), .ROM_AW(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_data(resp_data0), .resp_err(resp_err0),
    .rom_addr(rom_addr0), .rom_data(rom_data0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference rules: word aligned and inside the 4 KiB ROM window.
  function automatic bit ref_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] a);
    return ref_err(a) ? 32'd0 : rom_mem[a / 4];
  endfunction

  // One fetch on the WAIT_CYCLES=1 instance. hold = cycles of backpressure
  // once the response is visible; keep/nxt leave req_valid high with the next
  // address for back-to-back traffic.
  task automatic fetch(input logic [31:0] addr, input int hold, input bit keep,
                       input logic [31:0] nxt, output int acc_cyc);
    logic [9:0]  old_ra;
    logic [31:0] exp_d;
    bit          exp_e;
    int          n;
    exp_e = ref_err(addr);
    exp_d = ref_data(addr);
    old_ra = rom_addr;
    req_valid  = 1'b1;
    req_addr   = addr;
    resp_ready = 1'b0;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    acc_cyc   = cyc;
    req_valid = keep;
    req_addr  = keep ? nxt : $urandom;  // later changes must be ignored
    n = 1;
    while (!resp_valid && n < 40) begin
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      resp_ready = 1'($urandom % 2);    // ignored while resp_valid=0
      @(posedge clk); #1;
      n++;
    end
    resp_ready = 1'b0;
    chk("latency", 32'(n), exp_e ? 32'd1 : 32'(3 + W1));
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_data", resp_data, exp_d);
    chk("resp_err", 32'(resp_err), 32'(exp_e));
    chk("rom_addr", 32'(rom_addr), exp_e ? 32'(old_ra) : addr / 4);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_data, exp_d);
      chk("hold_err", 32'(resp_err), 32'(exp_e));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("done_valid", 32'(resp_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
    $display("txn addr=%h data=%h err=%0d latency=%0d hold=%0d", addr, resp_data, resp_err, n, hold);
  endtask

  int          acc_a, acc_b, acc_c, n0, kind;
  logic [31:0] a;
  logic [31:0] addrs0 [2];

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
    rom_mem[5] = 32'h8C220004;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    resetn = 1'b1;
    #1;
    chk("rst_release_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Basic fetch, then the same fetch under 6 cycles of backpressure
    fetch(32'h14, 0, 1'b0, 32'd0, acc_a);
    fetch(32'h14, 6, 1'b0, 32'd0, acc_a);

    // Misaligned and out-of-range errors
    fetch(32'h16, 0, 1'b0, 32'd0, acc_a);
    fetch(32'h00001000, 2, 1'b0, 32'd0, acc_a);

    // Back-to-back with req_valid held high
    fetch(32'h0, 0, 1'b1, 32'h4, acc_a);
    fetch(32'h4, 0, 1'b1, 32'h8, acc_b);
    fetch(32'h8, 0, 1'b0, 32'd0, acc_c);
    chk("b2b_spacing_1", 32'(acc_b - acc_a), 32'd5);
    chk("b2b_spacing_2", 32'(acc_c - acc_b), 32'd5);

    // Reset while in WAIT
    req_valid = 1'b1;
    req_addr  = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;          // now in the wait cycle
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_resp_data", resp_data, 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_req_ready_low", 32'(req_ready), 32'd0);
    resetn = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", 32'(resp_valid), 32'd0);
    end
    $display("txn reset during wait, no response expected");

    // Random fetches
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom % 4);
      case (kind)
        0, 1: a = ($urandom % 1024) * 4;
        2:    a = ($urandom % 1024) * 4 + 1 + ($urandom % 3);
        default: a = $urandom | 32'h1000;
      endcase
      fetch(a, int'($urandom % 4), 1'b0, 32'd0, acc_a);
    end

    // WAIT_CYCLES=0 instance: top word and one misaligned address
    addrs0[0] = 32'hFFC;
    addrs0[1] = 32'h2;
    for (int k = 0; k < 2; k++) begin
      req_valid0 = 1'b1;
      req_addr0  = addrs0[k];
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      n0 = 1;
      while (!resp_valid0 && n0 < 40) begin
        @(posedge clk); #1;
        n0++;
      end
      chk("w0_latency", 32'(n0), ref_err(addrs0[k]) ? 32'd1 : 32'd3);
      chk("w0_resp_data", resp_data0, ref_data(addrs0[k]));
      chk("w0_resp_err", 32'(resp_err0), 32'(ref_err(addrs0[k])));
      chk("w0_rom_addr", 32'(rom_addr0), 32'h3FF);
      resp_ready0 = 1'b1;
      @(posedge clk); #1;
      resp_ready0 = 1'b0;
      chk("w0_done_valid", 32'(resp_valid0), 32'd0);
      $display("txn w0 addr=%h data=%h err=%0d latency=%0d", addrs0[k], resp_data0, resp_err0, n0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_rom_responder.md
Name: instr_rom_responder

Overview:
- Responder side of the instruction-fetch interface: accepts one fetch request at a time from the fetch stage and returns the 32-bit instruction word.
- Drives a synchronous instruction ROM that samples its address on the rising edge of clk, with 1-cycle read latency.
- Adds programmable wait states to model slower memory.
- Checks address alignment and range, and returns an error response for illegal addresses.

Parameters:
- ADDR_W, 32, width of the request byte address.
- ROM_AW, 10, ROM word-address width; the ROM holds 2^ROM_AW words.
- WAIT_CYCLES, 1, extra delay cycles inserted before the response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  responder can accept a request.
- req_addr  input  ADDR_W  fetch byte address.
- resp_valid  output  1  response valid.
- resp_ready  input  1  requester accepts the response.
- resp_data  output  32  instruction word; 0 on an error response.
- resp_err  output  1  misaligned or out-of-range request.
- rom_addr  output  ROM_AW  registered word address to the ROM.
- rom_data  input  32  ROM output; valid the cycle after the ROM samples rom_addr.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state goes to IDLE.
  - resp_valid=0, resp_data=0, resp_err=0, rom_addr=0, wait counter=0.
  - req_ready=0 while resetn is low.
  - Reset mid-transaction discards the request; no response is ever produced for it.
- States: IDLE, READ, LATCH, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept fires on req_valid & req_ready at an edge (call it cycle 0).
- Address check at accept:
  - Error if req_addr[1:0] != 0, or if any bit of req_addr[ADDR_W-1:ROM_AW+2] != 0.
  - Error path: go to RESP with resp_data=0 and resp_err=1. The response is visible in cycle 1, and rom_addr is unchanged.
- Legal accept: rom_addr <= req_addr[ROM_AW+1:2], then go to READ.
- READ (cycle 1): the ROM samples rom_addr at the end of this cycle. Go to LATCH.
- LATCH (cycle 2): resp_data <= rom_data and resp_err <= 0 at the end of the cycle. Then:
  - WAIT_CYCLES=0: go to RESP.
  - Otherwise: load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0. WAIT lasts exactly WAIT_CYCLES cycles.
- RESP:
  - resp_valid=1, first asserted in cycle 3+WAIT_CYCLES after accept.
  - resp_data and resp_err stay stable until resp_valid & resp_ready at an edge; then go to IDLE with resp_valid=0.
- Handshake rules:
  - At most one request outstanding.
  - req_ready=0 in every state except IDLE, so a request is never accepted in the same cycle its response completes (one-cycle bubble).
  - Minimum legal-fetch period is 4+WAIT_CYCLES cycles; for errors it is 2 cycles.
- rom_addr holds its value between requests; the ROM may keep reading it harmlessly.
- req_addr is sampled only at accept; later changes have no effect.
- resp_ready while resp_valid=0 is ignored.
- resp_valid asserted with resp_ready low indefinitely: hold the response forever, with no timeout.

Test Plan:
1. WAIT_CYCLES=1, ROM word 5 = 0x8C220004; request req_addr=0x14 accepted in cycle 0 -> rom_addr=5 from cycle 1; resp_valid=1 in cycle 4 with resp_data=0x8C220004, resp_err=0; resp_ready=1 -> IDLE in cycle 5, req_ready=1.
2. Backpressure: same request with resp_ready=0 for 6 cycles after resp_valid rises -> resp_valid and resp_data stay constant throughout; req_ready=0 throughout; completes on the first resp_ready=1.
3. Errors, ROM_AW=10:
   - req_addr=0x16 (misaligned) -> resp_valid in cycle 1 with resp_err=1, resp_data=0, rom_addr unchanged.
   - req_addr=0x00001000 (out of range) -> same error response.
4. Back-to-back: req_valid held high with addrs 0x0, 0x4, 0x8 and resp_ready=1 -> three responses in order with correct ROM words; accepts spaced exactly 5 cycles apart (WAIT_CYCLES=1).
5. Reset mid-operation: drive resetn=0 for one edge during WAIT -> next cycle resp_valid=0, resp_data=0, rom_addr=0, req_ready=1 after reset deasserts; no stale response appears later.
6. WAIT_CYCLES=0 build: req_addr=0xFFC -> rom_addr=0x3FF; resp_valid in cycle 3 carrying ROM word 1023.
